// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg: generic elastic pipeline stage. DEPTH-entry in-order
// circular buffer between two pipeline stages with valid/ready on both sides,
// synchronous flush, and a configurable bubble payload on o_data when empty.
//
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset (discards all entries)
//   i_flush  - kill all held entries and the input beat of this cycle
//   i_valid  - upstream beat valid
//   i_data   - upstream payload [WIDTH]
//   o_ready  - stage accepts a beat this cycle
//   o_valid  - head entry valid
//   o_data   - head payload [WIDTH], BUBBLE when o_valid=0
//   i_ready  - downstream accepts head this cycle
//   o_count  - entries currently held [$clog2(DEPTH+1)]
module pipe_elastic_reg #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     DEPTH      = 2,
  parameter logic [WIDTH-1:0] BUBBLE    = '0,
  parameter bit              READY_PASS = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_not_full;
  logic w_push;
  logic w_pop;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode; flush suppresses both sides of the transfer.
  always_comb begin
    w_not_full = (r_count != FULL_CNT);
    o_ready    = w_not_full | (READY_PASS & i_ready);
    o_valid    = (r_count != '0);
    w_push     = i_valid & o_ready & ~i_flush;
    w_pop      = o_valid & i_ready & ~i_flush;
  end

  // Head mux: stored payload when valid, bubble otherwise.
  always_comb begin
    o_data  = BUBBLE;
    o_count = r_count;
    if (o_valid) begin
      o_data = r_mem[r_rd_ptr];
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Protocol checks (simulation).
  a_data_stable : assert property (@(posedge i_clk) disable iff (i_rst)
    (i_valid && !o_ready) |=> $stable(i_data));

  a_count_range : assert property (@(posedge i_clk) disable iff (i_rst)
    r_count <= FULL_CNT);

  a_bubble : assert property (@(posedge i_clk) disable iff (i_rst)
    !o_valid |-> (o_data == BUBBLE));

endmodule
